// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Define LEADING_ZERO_BLANK_EN to blank zero digits above the most significant nonzero digit.
module seg_scan_ctrl #(
  parameter int unsigned N_DIG = 4,
  parameter int unsigned PRESC = 50000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_valid_i,
  output logic               load_ready_o,
  input  logic [4*N_DIG-1:0] numar_i,
  input  logic [N_DIG-1:0]   dp_mask_i,
  output logic [7:0]         seg_o,
  output logic [N_DIG-1:0]   an_o,
  output logic               frame_done_o
);

  localparam int unsigned W_PRESC = $clog2(PRESC + 1);
  localparam int unsigned W_IDX   = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  // Shared digit converter: active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] e3_digit_to_7seg(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [W_PRESC-1:0] cnt_q, cnt_d;
  logic [W_IDX-1:0]   idx_q, idx_d;
  logic               tick, last_dig;

  logic [4*N_DIG-1:0] act_q, act_d, pend_q, pend_d;
  logic [N_DIG-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic               pend_vld_q, pend_vld_d;
  logic               ready_q, ready_d;

  logic [7:0]         seg_q, seg_d;
  logic [N_DIG-1:0]   an_q, an_d;

  assign tick         = (cnt_q == W_PRESC'(PRESC - 1));
  assign last_dig     = (idx_q == W_IDX'(N_DIG - 1));
  assign frame_done_o = tick & last_dig;
  assign load_ready_o = ready_q;
  assign seg_o        = seg_q;
  assign an_o         = an_q;

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = last_dig ? '0 : idx_q + 1'b1;
    end
  end

  // Promotion needs a full pending buffer and capture needs an empty one, so they never collide.
  always_comb begin
    act_d      = act_q;
    act_dp_d   = act_dp_q;
    pend_d     = pend_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    if (frame_done_o && pend_vld_q) begin
      act_d      = pend_q;
      act_dp_d   = pend_dp_q;
      pend_vld_d = 1'b0;
    end
    if (load_valid_i && ready_q) begin
      pend_d     = numar_i;
      pend_dp_d  = dp_mask_i;
      pend_vld_d = 1'b1;
    end
    ready_d = ~pend_vld_d;
  end

  always_comb begin
    logic [3:0] digit;
    logic       dp;
    logic       blank;
`ifdef LEADING_ZERO_BLANK_EN
    logic [W_IDX-1:0] msd;
`endif
    digit = '0;
    dp    = 1'b0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (idx_q == W_IDX'(i)) begin
        digit = act_q[4*i +: 4];
        dp    = act_dp_q[i];
      end
    end
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    msd = '0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (act_q[4*i +: 4] != 4'h0) msd = W_IDX'(i);
    end
    blank = (idx_q > msd);
`endif
    seg_d = 8'hFF;
    an_d  = '1;
    if (!blank) begin
      seg_d = {~dp, e3_digit_to_7seg(digit)};
      for (int unsigned i = 0; i < N_DIG; i++) begin
        if (idx_q == W_IDX'(i)) an_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      act_q      <= '0;
      act_dp_q   <= '0;
      pend_q     <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      seg_q      <= 8'hFF;
      an_q       <= '1;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_q      <= act_d;
      act_dp_q   <= act_dp_d;
      pend_q     <= pend_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (N_DIG=4, PRESC=4): expected frames are queued by the
// stimulus and checked mid-slot by a monitor that tracks frame boundaries.
module tb_seg_scan_ctrl;
  localparam int NDIG  = 4;
  localparam int PR    = 4;
  localparam int FRAME = NDIG * PR;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready_o;
  logic [15:0] numar = '0;
  logic [3:0]  dp_mask = '0;
  logic [7:0]  seg_o;
  logic [3:0]  an_o;
  logic        frame_done_o;

  seg_scan_ctrl #(.N_DIG(NDIG), .PRESC(PR)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready_o),
    .numar_i      (numar),
    .dp_mask_i    (dp_mask),
    .seg_o        (seg_o),
    .an_o         (an_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_cnt = 0;

  typedef struct {
    int         frame;
    int         slot;
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[d];
  endfunction

  task automatic push_frame(input int f, input logic [15:0] val, input logic [3:0] dp);
    int   msd;
    exp_t e;
    msd = 0;
    for (int i = 0; i < NDIG; i++) if (val[4*i +: 4] != 4'h0) msd = i;
    for (int s = 0; s < NDIG; s++) begin
      logic blank;
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = (s > msd);
`endif
      e.frame = f;
      e.slot  = s;
      e.an    = 4'hF;
      e.seg   = 8'hFF;
      if (!blank) begin
        e.an[s] = 1'b0;
        e.seg   = {~dp[s], seg7(val[4*s +: 4])};
      end
      q.push_back(e);
    end
  endtask

  // Monitor: frame k starts after the k-th frame_done; slot s is sampled 3+4s negedges later.
  bit synced = 1'b0;
  int off = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      synced = 1'b0;
    end else if (frame_done_o) begin
      if (synced) check("frame_period", off + 1, FRAME);
      frame_cnt++;
      synced = 1'b1;
      off = 0;
    end else if (synced) begin
      off++;
      if (off % PR == PR - 1 && off < FRAME) begin
        int   s;
        exp_t e;
        s = off / PR;
        while (q.size() > 0 && (q[0].frame < frame_cnt ||
               (q[0].frame == frame_cnt && q[0].slot < s))) begin
          e = q.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL missed_f%0d_s%0d: got no sample, required an=%b seg=%h",
                   e.frame, e.slot, e.an, e.seg);
        end
        if (q.size() > 0 && q[0].frame == frame_cnt && q[0].slot == s) begin
          e = q.pop_front();
          check($sformatf("display_f%0d_s%0d", e.frame, e.slot), {an_o, seg_o}, {e.an, e.seg});
        end
      end
    end
  end

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fd();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      sync();
      if (frame_done_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("frame_done_timeout", 0, 1);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp, output int fr);
    load_valid = 1'b1;
    numar      = v;
    dp_mask    = dp;
    fr         = -1;
    for (int i = 0; i < 200; i++) begin
      if (load_ready_o) begin
        fr = frame_cnt;
        break;
      end
      sync();
    end
    if (fr < 0) begin
      check("load_timeout", 0, 1);
      load_valid = 1'b0;
    end else begin
      @(posedge clk);
      sync();
      load_valid = 1'b0;
      check("ready_drop", {31'd0, load_ready_o}, 0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0) break;
      sync();
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, f1, f2, k;
    bit seen;
    // Reset values
    #23;
    check("rst_seg", seg_o, 8'hFF);
    check("rst_an", an_o, 4'hF);
    check("rst_ready", {31'd0, load_ready_o}, 1);
    check("rst_fd", {31'd0, frame_done_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_an", an_o, 4'b1110);
    check("first_seg", seg_o, 8'hC0);

    // Basic load, shown from the next frame boundary and persisting
    wait_fd();
    load(16'h1234, 4'b0000, f);
    push_frame(f + 1, 16'h1234, 4'b0000);
    push_frame(f + 2, 16'h1234, 4'b0000);
    drain();

    // Pending full: second value held off until the first is promoted
    wait_fd();
    load(16'h1111, 4'b0000, f1);
    load(16'h2222, 4'b0000, f2);
    check("hold_capture_frame", f2, f1 + 1);
    push_frame(f1 + 1, 16'h1111, 4'b0000);
    push_frame(f1 + 2, 16'h2222, 4'b0000);
    drain();

    // Decimal point on digit 1 only
    wait_fd();
    load(16'h5678, 4'b0010, f);
    push_frame(f + 1, 16'h5678, 4'b0010);
    drain();

    // Leading zeros (blanked only with LEADING_ZERO_BLANK_EN)
    wait_fd();
    load(16'h0050, 4'b0000, f);
    push_frame(f + 1, 16'h0050, 4'b0000);
    drain();

    // Load accepted in the frame_done cycle: old value for this frame, new one after
    wait_fd();
    load(16'hABCD, 4'b1000, f);
    push_frame(f, 16'h0050, 4'b0000);
    push_frame(f + 1, 16'hABCD, 4'b1000);
    drain();

    // Asynchronous reset in digit 2's slot with a value pending
    wait_fd();
    load(16'h9999, 4'b1111, f);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (an_o == 4'b1011) begin
        seen = 1'b1;
        break;
      end
      sync();
    end
    check("reach_digit2", {31'd0, seen}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_seg", seg_o, 8'hFF);
    check("async_rst_an", an_o, 4'hF);
    check("async_rst_ready", {31'd0, load_ready_o}, 1);
    check("async_rst_fd", {31'd0, frame_done_o}, 0);
    repeat (3) sync();
    rst_n = 1'b1;
    wait_fd();
    k = frame_cnt;
    push_frame(k, 16'h0000, 4'b0000);
    push_frame(k + 1, 16'h0000, 4'b0000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
